// File: rtl/mc_sysctl.sv
// mc_sysctl: board system-control slave for MC1201-family processor modules.
// Shadow-ROM window decode with a programmable-latency ack, the startup
// register (SEL1) with a write mask, even/odd SEL2 registers and debounced
// toggle buttons gating 50 Hz interrupt lines. Single clock domain (clk_p).
//
// ROM handshake: wb_cyc_i & wb_stb_i on a decoded ROM address is the request
// (valid). The master must hold it, with a stable address, until rom_ack_o
// (ready) is seen high. rom_ack_o stays high for as long as the request is
// held, and drops on the first clk_p edge after the request goes away.
// Dropping the request in any state aborts the transaction back to IDLE.
module mc_sysctl #(
  parameter logic [1:0]  STARTUP    = 2'b01,
  parameter logic [7:0]  START_HI   = 8'o340,
  parameter logic [3:0]  ROM_BITS   = 4'b0000,
  parameter logic [15:0] WMASK      = 16'h00FC,
  parameter int          ROM_WAIT   = 1,
  parameter int          NBTN       = 1,
  parameter int          DEB_LEN    = 2,
  parameter logic        TIMER_INIT = 1'b1
) (
  input  logic            clk_p,
  input  logic            dclo_n,
  input  logic [15:0]     wb_adr_i,
  input  logic [15:0]     wb_dat_i,
  input  logic [1:0]      wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:1]      vm_sel,
  output logic            rom_stb_o,
  output logic            rom_ack_o,
  output logic [15:0]     startup_reg_o,
  output logic [15:0]     sel2_even_o,
  output logic [15:0]     sel2_odd_o,
  input  logic            timer_50,
  input  logic [NBTN-1:0] btn_i,
  output logic [NBTN-1:0] status_o,
  output logic [NBTN-1:0] irq_o,
  output logic [1:0]      dbg_rom_state_o   // ROM FSM state: 0 IDLE, 1 WAIT, 2 ACK
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } rom_state_t;

  localparam logic [15:0] STARTUP_RST = {START_HI, 2'b00, ROM_BITS, STARTUP};

  rom_state_t          r_state;
  rom_state_t          w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_ack;
  logic                w_rom_stb;
  logic [15:0]         r_startup;
  logic [15:0]         r_even;
  logic [15:0]         r_odd;
  logic [15:0]         w_sel1_mask;
  logic [2:0]          r_tmr_s;
  logic                w_tmr_lvl;
  logic                w_tick;
  logic [NBTN-1:0]     r_btn_s1;
  logic [NBTN-1:0]     r_btn_s2;
  logic [DEB_LEN-1:0]  r_deb [NBTN];
  logic [DEB_LEN-1:0]  w_deb_nxt [NBTN];
  logic [NBTN-1:0]     r_ev;
  logic [NBTN-1:0]     r_status;
  logic                w_unused_adr;

  // Address bits [8:1] play no part in any decode.
  assign w_unused_adr = ^wb_adr_i[8:1];

  // ROM window decode: low ROM at 160000-163777 (s[2] or s[3]), high ROM
  // 164000-173777 (s[3]), and 173000-173777 always present.
  always_comb begin
    w_rom_stb = 1'b0;
    if (wb_cyc_i && wb_stb_i && (wb_adr_i[15:13] == 3'b111)) begin
      if ((wb_adr_i[12:11] == 2'b00) && (r_startup[2] || r_startup[3]))
        w_rom_stb = 1'b1;
      if (((wb_adr_i[12:11] == 2'b01) || (wb_adr_i[12:11] == 2'b10)) && r_startup[3])
        w_rom_stb = 1'b1;
      if (wb_adr_i[12:9] == 4'b1011)
        w_rom_stb = 1'b1;
    end
  end

  // ROM FSM next state: count ROM_WAIT cycles in WAIT, then hold ACK while requested.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    if (!w_rom_stb) begin
      w_next    = ST_IDLE;
      w_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = 4'd0;
          w_next    = (ROM_WAIT == 0) ? ST_ACK : ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == 4'(ROM_WAIT - 1)) w_next = ST_ACK;
          else                           w_cnt_nxt = r_cnt + 4'd1;
        end
        ST_ACK:  w_next = ST_ACK;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // ROM FSM state, wait counter and registered ack.
  always_ff @(posedge clk_p or negedge dclo_n) begin
    if (!dclo_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= (w_next == ST_ACK);
    end
  end

  assign w_sel1_mask = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}} & WMASK;

  // SEL1 (byte-selected, masked) and SEL2 even/odd register writes.
  always_ff @(posedge clk_p or negedge dclo_n) begin
    if (!dclo_n) begin
      r_startup <= STARTUP_RST;
      r_even    <= 16'd0;
      r_odd     <= 16'd0;
    end else if (wb_we_i) begin
      if (vm_sel[1])
        r_startup <= (r_startup & ~w_sel1_mask) | (wb_dat_i & w_sel1_mask);
      if (vm_sel[2]) begin
        if (wb_adr_i[0]) r_odd  <= wb_dat_i;
        else             r_even <= wb_dat_i;
      end
    end
  end

  // Synchronisers for the 50 Hz tick and the raw buttons.
  always_ff @(posedge clk_p or negedge dclo_n) begin
    if (!dclo_n) begin
      r_tmr_s  <= 3'b000;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_tmr_s  <= {r_tmr_s[1:0], timer_50};
      r_btn_s1 <= btn_i;
      r_btn_s2 <= r_btn_s1;
    end
  end

  assign w_tmr_lvl = r_tmr_s[1];
  assign w_tick    = r_tmr_s[1] & ~r_tmr_s[2];

  // Shift window after taking this tick's sample, per channel.
  always_comb begin
    for (int i = 0; i < NBTN; i++)
      w_deb_nxt[i] = {r_deb[i][DEB_LEN-2:0], r_btn_s2[i]};
  end

  // Debounce: a full window of ones toggles once; a full window of zeros re-arms.
  always_ff @(posedge clk_p or negedge dclo_n) begin
    if (!dclo_n) begin
      for (int i = 0; i < NBTN; i++) r_deb[i] <= '0;
      r_ev     <= '0;
      r_status <= {NBTN{TIMER_INIT}};
    end else if (w_tick) begin
      for (int i = 0; i < NBTN; i++) begin
        r_deb[i] <= w_deb_nxt[i];
        if ((&w_deb_nxt[i]) && !r_ev[i]) begin
          r_status[i] <= ~r_status[i];
          r_ev[i]     <= 1'b1;
        end else if (~|w_deb_nxt[i]) begin
          r_ev[i] <= 1'b0;
        end
      end
    end
  end

  assign rom_stb_o       = w_rom_stb;
  assign rom_ack_o       = r_ack;
  assign startup_reg_o   = r_startup;
  assign sel2_even_o     = r_even;
  assign sel2_odd_o      = r_odd;
  assign status_o        = r_status;
  assign irq_o           = {NBTN{w_tmr_lvl}} & r_status;
  assign dbg_rom_state_o = r_state;

endmodule

// File: tb/tb_mc_sysctl.sv
// Bench for mc_sysctl: three instances (ROM_WAIT 1/0/3) sharing one bus,
// compared against an address-range / run-length reference model.
module tb_mc_sysctl;

  localparam int DEB = 2;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  logic clk_p = 1'b0;
  logic dclo_n;
  always #5 clk_p = ~clk_p;

  logic [15:0] wb_adr, wb_dat;
  logic [1:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [2:1]  vm_sel;
  logic        timer_50;
  logic [1:0]  btn;

  logic        w1_stb, w1_ack, w0_stb, w0_ack, w3_stb, w3_ack;
  logic [15:0] w1_s, w1_even, w1_odd, w0_s, w0_even, w0_odd, w3_s, w3_even, w3_odd;
  logic [0:0]  w1_status, w1_irq, w0_status, w0_irq;
  logic [1:0]  w3_status, w3_irq;
  logic [1:0]  w1_dbg, w0_dbg, w3_dbg;

  mc_sysctl u_w1 (
    .clk_p(clk_p), .dclo_n(dclo_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .vm_sel(vm_sel), .rom_stb_o(w1_stb), .rom_ack_o(w1_ack), .startup_reg_o(w1_s),
    .sel2_even_o(w1_even), .sel2_odd_o(w1_odd), .timer_50(timer_50),
    .btn_i(btn[0:0]), .status_o(w1_status), .irq_o(w1_irq), .dbg_rom_state_o(w1_dbg)
  );

  mc_sysctl #(.ROM_WAIT(0)) u_w0 (
    .clk_p(clk_p), .dclo_n(dclo_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .vm_sel(vm_sel), .rom_stb_o(w0_stb), .rom_ack_o(w0_ack), .startup_reg_o(w0_s),
    .sel2_even_o(w0_even), .sel2_odd_o(w0_odd), .timer_50(timer_50),
    .btn_i(btn[0:0]), .status_o(w0_status), .irq_o(w0_irq), .dbg_rom_state_o(w0_dbg)
  );

  mc_sysctl #(.ROM_WAIT(3), .NBTN(2)) u_w3 (
    .clk_p(clk_p), .dclo_n(dclo_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .vm_sel(vm_sel), .rom_stb_o(w3_stb), .rom_ack_o(w3_ack), .startup_reg_o(w3_s),
    .sel2_even_o(w3_even), .sel2_odd_o(w3_odd), .timer_50(timer_50),
    .btn_i(btn), .status_o(w3_status), .irq_o(w3_irq), .dbg_rom_state_o(w3_dbg)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_s, m_even, m_odd;
  logic [15:0] wmask_v = 16'h00FC;
  int          run1 [2];
  int          run0 [2];
  logic        m_ev [2];
  logic        m_st [2];

  task automatic m_reset();
    m_s = 16'o160001; m_even = 16'd0; m_odd = 16'd0;
    for (int c = 0; c < 2; c++) begin
      run1[c] = 0; run0[c] = DEB; m_ev[c] = 1'b0; m_st[c] = 1'b1;
    end
  endtask

  // Decoded ROM window as address ranges.
  function automatic logic m_rom(input logic [15:0] a, input logic [15:0] s, input logic cs);
    if (!cs) return 1'b0;
    if (a >= 16'o160000 && a <= 16'o163777) return s[2] | s[3];
    if (a >= 16'o173000 && a <= 16'o173777) return 1'b1;
    if (a >= 16'o164000 && a <= 16'o172777) return s[3];
    return 1'b0;
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] sl,
                         input logic [2:1] vs, input logic we);
    if (we && vs[1])
      for (int k = 0; k < 16; k++)
        if (sl[k / 8] && wmask_v[k]) m_s[k] = d[k];
    if (we && vs[2]) begin
      if (a[0]) m_odd = d;
      else      m_even = d;
    end
  endtask

  // Button press counted in run lengths of identical samples.
  task automatic m_tick(input logic [1:0] b);
    for (int c = 0; c < 2; c++) begin
      if (b[c]) begin run1[c]++; run0[c] = 0; end
      else      begin run0[c]++; run1[c] = 0; end
      if (run1[c] >= DEB && !m_ev[c]) begin m_st[c] = ~m_st[c]; m_ev[c] = 1'b1; end
      if (run0[c] >= DEB) m_ev[c] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk_p); #1; end
  endtask

  task automatic bus_idle();
    wb_cyc = 0; wb_stb = 0; wb_we = 0; vm_sel = 2'b00; wb_sel = 2'b00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] sl,
                    input logic [2:1] vs, input logic we);
    wb_adr = a; wb_dat = d; wb_sel = sl; vm_sel = vs; wb_we = we; wb_cyc = 1; wb_stb = 1;
    step(1);
    m_write(a, d, sl, vs, we);
    bus_idle();
    check("sel1_w1", w1_s, m_s);
    check("sel1_w3", w3_s, m_s);
    check("even_w1", w1_even, m_even);
    check("odd_w1", w1_odd, m_odd);
  endtask

  task automatic rom_probe(input logic [15:0] a, input logic cs);
    wb_adr = a; wb_cyc = cs; wb_stb = cs; wb_we = 0; vm_sel = 2'b00;
    #1;
    check("rom_stb_w1", w1_stb, m_rom(a, m_s, cs));
    check("rom_stb_w0", w0_stb, m_rom(a, m_s, cs));
    step(1);
    bus_idle();
  endtask

  task automatic rom_latency();
    int l1, l0, l3;
    l1 = 0; l0 = 0; l3 = 0;
    bus_idle(); step(2);
    wb_adr = 16'o173000; wb_cyc = 1; wb_stb = 1;
    #1;
    check("lat_stb_same_cycle", w1_stb, 1);
    check("lat_ack_early", w1_ack, 0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk_p); #1;
      if (l1 == 0 && w1_ack) l1 = c;
      if (l0 == 0 && w0_ack) l0 = c;
      if (l3 == 0 && w3_ack) l3 = c;
    end
    check("lat_wait1", l1, 2);
    check("lat_wait0", l0, 1);
    check("lat_wait3", l3, 4);
    check("ack_held", {w1_ack, w0_ack, w3_ack}, 3'b111);
    bus_idle();
    step(1);
    check("ack_drop", {w1_ack, w0_ack, w3_ack}, 3'b000);
    check("fsm_idle_w3", w3_dbg, 0);
  endtask

  task automatic tick_btn(input logic [1:0] b);
    btn = b;
    step(4);
    m_tick(b);
    timer_50 = 1;
    step(6);
    check("status_w1", w1_status, m_st[0]);
    check("status_w0", w0_status, m_st[0]);
    check("status_w3", w3_status, {m_st[1], m_st[0]});
    check("irq_hi_w1", w1_irq, m_st[0]);
    check("irq_hi_w3", w3_irq, {m_st[1], m_st[0]});
    timer_50 = 0;
    step(4);
    check("irq_lo_w3", w3_irq, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  b;
    logic [15:0] a;
    dclo_n = 0; timer_50 = 0; btn = 2'b00; wb_adr = 0; wb_dat = 0;
    bus_idle();
    m_reset();
    #12;
    check("rst_startup", w1_s, 16'o160001);
    check("rst_even", w1_even, 0);
    check("rst_odd", w1_odd, 0);
    check("rst_status_w1", w1_status, 1);
    check("rst_status_w3", w3_status, 2'b11);
    check("rst_ack", w1_ack, 0);
    check("rst_fsm", w1_dbg, 0);
    check("rst_irq", w3_irq, 0);
    @(negedge clk_p); dclo_n = 1;
    step(1);

    // Low ROM hidden while s[3:2]=0
    rom_probe(16'o160000, 1'b1);
    check("low_rom_hidden", w1_stb, 0);
    rom_latency();

    // Directed register writes
    wr(16'o177700, 16'hFFFF, 2'b11, 2'b01, 1'b1);
    check("sel1_all_ones", w1_s, 16'o160375);
    wb_adr = 16'o160000; wb_cyc = 1; wb_stb = 1; #1;
    check("low_rom_enabled", w1_stb, 1);
    step(1); bus_idle();
    wr(16'o177700, 16'h00FF, 2'b10, 2'b01, 1'b1);
    check("sel1_hi_byte", w1_s, 16'o160375);
    wr(16'o177701, 16'h1234, 2'b11, 2'b10, 1'b1);
    check("sel2_odd", w1_odd, 16'h1234);
    check("sel2_even_kept", w1_even, 0);

    // Random writes and decode probes
    for (int i = 0; i < 40; i++) begin
      wr(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
         2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(16'o160000, 16'o177777));
      rom_probe(a, 1'($urandom_range(0, 7) != 0));
    end
    rom_latency();

    // Debounce: long press, bounce, release, press again, dual press
    for (int i = 0; i < DEB + 3; i++) tick_btn(2'b01);
    for (int i = 0; i < 3; i++) tick_btn(2'b00);
    tick_btn(2'b01); tick_btn(2'b00); tick_btn(2'b01);
    for (int i = 0; i < 3; i++) tick_btn(2'b00);
    for (int i = 0; i < 5; i++) tick_btn(2'b01);
    for (int i = 0; i < 3; i++) tick_btn(2'b00);
    for (int i = 0; i < DEB + 1; i++) tick_btn(2'b11);
    for (int i = 0; i < 3; i++) tick_btn(2'b00);
    b = 2'b00;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) b = 2'($urandom_range(0, 3));
      tick_btn(b);
    end

    // Reset during ROM wait and mid-debounce
    tick_btn(2'b11);
    wb_adr = 16'o173000; wb_cyc = 1; wb_stb = 1;
    step(2);
    check("pre_rst_w3_waiting", w3_ack, 0);
    dclo_n = 0;
    #1;
    m_reset();
    check("mid_rst_ack_w3", w3_ack, 0);
    check("mid_rst_ack_w1", w1_ack, 0);
    check("mid_rst_fsm_w3", w3_dbg, 0);
    check("mid_rst_status_w3", w3_status, 2'b11);
    check("mid_rst_status_w1", w1_status, 1);
    check("mid_rst_startup", w1_s, 16'o160001);
    check("mid_rst_odd", w1_odd, 0);
    bus_idle();
    step(2);
    dclo_n = 1;
    step(1);
    for (int i = 0; i < DEB; i++) tick_btn(2'b11);
    for (int i = 0; i < 2; i++) tick_btn(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
